// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Funnels up to two retired ROB results per cycle into the single commit
// write port of the register file. Results are queued in program order and
// drained one per cycle through a registered write interface. A tag lookup
// over everything still in flight (queue + output register) keeps the issue
// path from reading a stale value for a retired but not yet written result.
//
// Build option: define RF_WBQ_BYPASS_EN to let the oldest valid slot skip
// the queue when it is empty, saving one cycle of write latency.
module rf_wb_arbiter #(
   parameter int DEPTH   = 4,
   parameter int REG_BIT = 5,
   parameter int ROB_BIT = 4,
   parameter int DAT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               br_flag,
   input  logic               c0_en_i,
   input  logic [REG_BIT-1:0] c0_rd_i,
   input  logic [ROB_BIT-1:0] c0_q_i,
   input  logic [DAT_W-1:0]   c0_v_i,
   input  logic               c1_en_i,
   input  logic [REG_BIT-1:0] c1_rd_i,
   input  logic [ROB_BIT-1:0] c1_q_i,
   input  logic [DAT_W-1:0]   c1_v_i,
   output logic               rob_stall_o,
   output logic               wr_en_o,
   output logic [REG_BIT-1:0] wr_rd_o,
   output logic [ROB_BIT-1:0] wr_q_o,
   output logic [DAT_W-1:0]   wr_v_o,
   input  logic [ROB_BIT-1:0] qry_j_i,
   input  logic [ROB_BIT-1:0] qry_k_i,
   output logic               hit_j_o,
   output logic               hit_k_o,
   output logic [DAT_W-1:0]   val_j_o,
   output logic [DAT_W-1:0]   val_k_o,
   output logic               ovf_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // queue storage; contents are only meaningful between rd_ptr and wr_ptr
   logic [REG_BIT-1:0] rd_mem [DEPTH];
   logic [ROB_BIT-1:0] q_mem  [DEPTH];
   logic [DAT_W-1:0]   v_mem  [DEPTH];

   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               wr_en_q, wr_en_d;
   logic [REG_BIT-1:0] wr_rd_q, wr_rd_d;
   logic [ROB_BIT-1:0] wr_q_q, wr_q_d;
   logic [DAT_W-1:0]   wr_v_q, wr_v_d;
   logic               ovf_q, ovf_d;

   // ordered enqueue candidates: a is always older than b
   logic               c0_ok, c1_ok;
   logic               a_vld, b_vld;
   logic [REG_BIT-1:0] a_rd, b_rd;
   logic [ROB_BIT-1:0] a_q, b_q;
   logic [DAT_W-1:0]   a_v, b_v;
   logic               deq;
   logic [1:0]         n_enq;
   logic [CNT_W-1:0]   free_slots;
   logic               we0, we1;
   logic [PTR_W-1:0]   wa0, wa1;

   // Queued entries are already architectural, so a mispredict has no effect
   // here; the flush input is kept only for a uniform ROB-side interface.
   logic unused_br_flag;
   assign unused_br_flag = br_flag;

   // next-state: dequeue to the output register, optional bypass, enqueue
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      wr_en_d  = wr_en_q;
      wr_rd_d  = wr_rd_q;
      wr_q_d   = wr_q_q;
      wr_v_d   = wr_v_q;
      ovf_d    = ovf_q;
      we0      = 1'b0;
      we1      = 1'b0;
      wa0      = wr_ptr_q;
      wa1      = wr_ptr_q + 1'b1;
      n_enq    = 2'd0;
      deq      = 1'b0;

      c0_ok      = c0_en_i && (c0_rd_i != '0);
      c1_ok      = c1_en_i && (c1_rd_i != '0);
      free_slots = CNT_W'(DEPTH) - count_q;

      a_vld = c0_ok || c1_ok;
      a_rd  = c0_ok ? c0_rd_i : c1_rd_i;
      a_q   = c0_ok ? c0_q_i  : c1_q_i;
      a_v   = c0_ok ? c0_v_i  : c1_v_i;
      b_vld = c0_ok && c1_ok;
      b_rd  = c1_rd_i;
      b_q   = c1_q_i;
      b_v   = c1_v_i;

      if (en) begin
         wr_en_d = 1'b0;
         if (count_q != '0) begin
            deq      = 1'b1;
            wr_en_d  = 1'b1;
            wr_rd_d  = rd_mem[rd_ptr_q];
            wr_q_d   = q_mem[rd_ptr_q];
            wr_v_d   = v_mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
`ifdef RF_WBQ_BYPASS_EN
         // empty queue: the oldest slot goes straight to the write port and
         // the younger one (if any) takes its place as the enqueue candidate
         else if (a_vld) begin
            wr_en_d = 1'b1;
            wr_rd_d = a_rd;
            wr_q_d  = a_q;
            wr_v_d  = a_v;
            a_vld   = b_vld;
            a_rd    = b_rd;
            a_q     = b_q;
            a_v     = b_v;
            b_vld   = 1'b0;
         end
`endif
         // space is judged against the registered count, so a slot freed by
         // this cycle's dequeue is not reused until next cycle
         if (a_vld) begin
            if (free_slots >= CNT_W'(1)) we0 = 1'b1;
            else                         ovf_d = 1'b1;
         end
         if (b_vld) begin
            if (free_slots >= CNT_W'(2)) we1 = 1'b1;
            else                         ovf_d = 1'b1;
         end
         n_enq    = {1'b0, we0} + {1'b0, we1};
         wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
         count_d  = count_q + CNT_W'(n_enq) - CNT_W'(deq);
      end
   end

   // control and write-port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         wr_en_q  <= 1'b0;
         wr_rd_q  <= '0;
         wr_q_q   <= '0;
         wr_v_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         wr_en_q  <= wr_en_d;
         wr_rd_q  <= wr_rd_d;
         wr_q_q   <= wr_q_d;
         wr_v_q   <= wr_v_d;
         ovf_q    <= ovf_d;
      end
   end

   // queue storage writes; two ports at consecutive slots, no reset needed
   always_ff @(posedge clk) begin
      if (we0) begin
         rd_mem[wa0] <= a_rd;
         q_mem[wa0]  <= a_q;
         v_mem[wa0]  <= a_v;
      end
      if (we1) begin
         rd_mem[wa1] <= b_rd;
         q_mem[wa1]  <= b_q;
         v_mem[wa1]  <= b_v;
      end
   end

   // in-flight lookup: output register first, then queue oldest to youngest
   // so the youngest match overrides anything older
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx     = '0;
      hit_j_o = 1'b0;
      hit_k_o = 1'b0;
      val_j_o = '0;
      val_k_o = '0;
      if (wr_en_q && (wr_q_q == qry_j_i) && (qry_j_i != '0)) begin
         hit_j_o = 1'b1;
         val_j_o = wr_v_q;
      end
      if (wr_en_q && (wr_q_q == qry_k_i) && (qry_k_i != '0)) begin
         hit_k_o = 1'b1;
         val_k_o = wr_v_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            if ((q_mem[idx] == qry_j_i) && (qry_j_i != '0)) begin
               hit_j_o = 1'b1;
               val_j_o = v_mem[idx];
            end
            if ((q_mem[idx] == qry_k_i) && (qry_k_i != '0)) begin
               hit_k_o = 1'b1;
               val_k_o = v_mem[idx];
            end
         end
      end
   end

   assign rob_stall_o = (count_q >= CNT_W'(DEPTH - 2));
   assign wr_en_o     = wr_en_q;
   assign wr_rd_o     = wr_rd_q;
   assign wr_q_o      = wr_q_q;
   assign wr_v_o      = wr_v_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_rf_wb_arbiter;

   localparam int DEPTH   = 4;
   localparam int REG_BIT = 5;
   localparam int ROB_BIT = 4;
   localparam int DAT_W   = 32;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               br_flag;
   logic               c0_en_i, c1_en_i;
   logic [REG_BIT-1:0] c0_rd_i, c1_rd_i;
   logic [ROB_BIT-1:0] c0_q_i, c1_q_i;
   logic [DAT_W-1:0]   c0_v_i, c1_v_i;
   logic               rob_stall_o;
   logic               wr_en_o;
   logic [REG_BIT-1:0] wr_rd_o;
   logic [ROB_BIT-1:0] wr_q_o;
   logic [DAT_W-1:0]   wr_v_o;
   logic [ROB_BIT-1:0] qry_j_i, qry_k_i;
   logic               hit_j_o, hit_k_o;
   logic [DAT_W-1:0]   val_j_o, val_k_o;
   logic               ovf_o;

   rf_wb_arbiter #(
      .DEPTH(DEPTH), .REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT), .DAT_W(DAT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .br_flag(br_flag),
      .c0_en_i(c0_en_i), .c0_rd_i(c0_rd_i), .c0_q_i(c0_q_i), .c0_v_i(c0_v_i),
      .c1_en_i(c1_en_i), .c1_rd_i(c1_rd_i), .c1_q_i(c1_q_i), .c1_v_i(c1_v_i),
      .rob_stall_o(rob_stall_o),
      .wr_en_o(wr_en_o), .wr_rd_o(wr_rd_o), .wr_q_o(wr_q_o), .wr_v_o(wr_v_o),
      .qry_j_i(qry_j_i), .qry_k_i(qry_k_i),
      .hit_j_o(hit_j_o), .hit_k_o(hit_k_o),
      .val_j_o(val_j_o), .val_k_o(val_k_o),
      .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [REG_BIT-1:0] rd;
      logic [ROB_BIT-1:0] q;
      logic [DAT_W-1:0]   v;
   } ent_t;

   // reference model: in-order pending list plus the entry being written
   ent_t mq[$];
   ent_t m_out;
   bit   m_out_vld;
   bit   m_ovf;

   logic [ROB_BIT-1:0] wr_log[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic ent_t mk_ent(input logic [REG_BIT-1:0] rd, input logic [ROB_BIT-1:0] q,
                                   input logic [DAT_W-1:0] v);
      ent_t e;
      e.rd = rd;
      e.q  = q;
      e.v  = v;
      return e;
   endfunction

   // youngest pending match wins; the entry on the write port is the oldest
   task automatic m_lookup(input logic [ROB_BIT-1:0] tag, output bit hit, output logic [DAT_W-1:0] val);
      hit = 1'b0;
      val = '0;
      if (tag != '0) begin
         for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
            if (mq[i].q == tag) begin
               hit = 1'b1;
               val = mq[i].v;
            end
         end
         if (!hit && m_out_vld && m_out.q == tag) begin
            hit = 1'b1;
            val = m_out.v;
         end
      end
   endtask

   task automatic model_step();
      ent_t reqs[$];
      int   free;
      if (en) begin
         free = DEPTH - mq.size();
         if (c0_en_i && c0_rd_i != '0) reqs.push_back(mk_ent(c0_rd_i, c0_q_i, c0_v_i));
         if (c1_en_i && c1_rd_i != '0) reqs.push_back(mk_ent(c1_rd_i, c1_q_i, c1_v_i));
         if (mq.size() > 0) begin
            m_out     = mq.pop_front();
            m_out_vld = 1'b1;
         end else begin
            m_out_vld = 1'b0;
`ifdef RF_WBQ_BYPASS_EN
            if (reqs.size() > 0) begin
               m_out     = reqs.pop_front();
               m_out_vld = 1'b1;
            end
`endif
         end
         foreach (reqs[i]) begin
            if (free > 0) begin
               mq.push_back(reqs[i]);
               free--;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      bit               h;
      logic [DAT_W-1:0] v;
      check_val("wr_en", wr_en_o, m_out_vld);
      if (m_out_vld) begin
         check_val("wr_rd", wr_rd_o, m_out.rd);
         check_val("wr_q", wr_q_o, m_out.q);
         check_val("wr_v", wr_v_o, m_out.v);
      end
      if (wr_en_o) wr_log.push_back(wr_q_o);
      check_val("stall", rob_stall_o, (mq.size() >= DEPTH - 2));
      check_val("ovf", ovf_o, m_ovf);
      m_lookup(qry_j_i, h, v);
      check_val("hit_j", hit_j_o, h);
      check_val("val_j", val_j_o, v);
      m_lookup(qry_k_i, h, v);
      check_val("hit_k", hit_k_o, h);
      check_val("val_k", val_k_o, v);
   endtask

   // called just after a falling edge with inputs already driven
   task automatic step();
      #1 check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      en      = 1'b1;
      br_flag = 1'b0;
      c0_en_i = 1'b0; c0_rd_i = '0; c0_q_i = '0; c0_v_i = '0;
      c1_en_i = 1'b0; c1_rd_i = '0; c1_q_i = '0; c1_v_i = '0;
   endtask

   task automatic drive(input bit e0, input int rd0, input int q0, input logic [DAT_W-1:0] v0,
                        input bit e1, input int rd1, input int q1, input logic [DAT_W-1:0] v1);
      en      = 1'b1;
      c0_en_i = e0; c0_rd_i = REG_BIT'(rd0); c0_q_i = ROB_BIT'(q0); c0_v_i = v0;
      c1_en_i = e1; c1_rd_i = REG_BIT'(rd1); c1_q_i = ROB_BIT'(q1); c1_v_i = v1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mq.delete();
      m_out_vld = 1'b0;
      m_out     = '0;
      m_ovf     = 1'b0;
      #2;
      check_outputs();
      check_val("rst_rd", wr_rd_o, 0);
      check_val("rst_q", wr_q_o, 0);
      check_val("rst_v", wr_v_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      int tag;
      rst_n   = 1'b0;
      qry_j_i = '0;
      qry_k_i = '0;
      idle();
      @(negedge clk);
      do_reset();

      // single commit is written once with its own fields
      wr_log.delete();
      drive(1, 5, 3, 32'h1234, 0, 0, 0, 0);
      step();
      idle();
      repeat (4) step();
      check_val("t1_nwr", wr_log.size(), 1);
      if (wr_log.size() > 0) check_val("t1_q", wr_log[0], 3);

      // two commits in one cycle drain in order
      wr_log.delete();
      drive(1, 1, 1, 32'hA, 1, 2, 2, 32'hB);
      step();
      idle();
      repeat (4) step();
      check_val("t2_nwr", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         check_val("t2_first", wr_log[0], 1);
         check_val("t2_second", wr_log[1], 2);
      end

      // rd==0 slot is discarded
      wr_log.delete();
      drive(1, 0, 5, 32'h77, 1, 7, 4, 32'h9);
      step();
      idle();
      check_val("t3_stall", rob_stall_o, 0);
      repeat (4) step();
      check_val("t3_nwr", wr_log.size(), 1);
      if (wr_log.size() > 0) check_val("t3_q", wr_log[0], 4);

      // lookup of a pending result while the queue is busy
      wr_log.delete();
      drive(1, 3, 8, 32'h11, 1, 4, 6, 32'h55);
      step();
      idle();
      qry_j_i = 4'd6;
      qry_k_i = 4'd0;
      #1;
      check_val("t4_hit", hit_j_o, 1);
      check_val("t4_val", val_j_o, 32'h55);
      check_val("t4_q0_hit", hit_k_o, 0);
      step();
      repeat (4) step();

      // flush does not disturb queued entries
      wr_log.delete();
      drive(1, 1, 9, 32'h90, 1, 2, 10, 32'hA0);
      step();
      drive(1, 3, 11, 32'hB0, 1, 4, 12, 32'hC0);
      step();
      idle();
      br_flag = 1'b1;
      step();
      br_flag = 1'b0;
      repeat (5) step();
      check_val("t5_nwr", wr_log.size(), 4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++)
         check_val("t5_order", wr_log[i], 9 + i);
      #1;
      check_val("t5_empty_stall", rob_stall_o, 0);
      check_val("t5_empty_wr", wr_en_o, 0);
      @(negedge clk);

      // overflow: present pairs regardless of stall until three are queued
      wr_log.delete();
      tag = 1;
      for (int g = 0; g < 10 && mq.size() < 3; g++) begin
         drive(1, 1, tag, 32'(tag), 1, 2, tag + 1, 32'(tag + 1));
         tag += 2;
         step();
      end
      check_val("t6_stall", rob_stall_o, 1);
      drive(1, 5, 14, 32'hE0, 1, 6, 15, 32'hF0);
      step();
      idle();
      #1;
      check_val("t6_ovf", ovf_o, 1);
      step();
      repeat (6) step();
      check_val("t6_ovf_hold", ovf_o, 1);
      found = 1'b0;
      foreach (wr_log[i]) if (wr_log[i] == 4'd15) found = 1'b1;
      check_val("t6_c1_dropped", found, 0);
      found = 1'b0;
      foreach (wr_log[i]) if (wr_log[i] == 4'd14) found = 1'b1;
      check_val("t6_c0_kept", found, 1);
      do_reset();

      // random traffic, including enable gaps, flushes and mid-drain resets
      for (int cyc = 0; cyc < 800; cyc++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         en      = ($urandom_range(0, 9) != 0);
         br_flag = ($urandom_range(0, 7) == 0);
         c0_en_i = 1'($urandom_range(0, 1));
         c0_rd_i = REG_BIT'($urandom_range(0, 3));
         c0_q_i  = ROB_BIT'($urandom_range(0, 15));
         c0_v_i  = $urandom;
         c1_en_i = 1'($urandom_range(0, 1));
         c1_rd_i = REG_BIT'($urandom_range(0, 3));
         c1_q_i  = ROB_BIT'($urandom_range(0, 15));
         c1_v_i  = $urandom;
         if (rob_stall_o && $urandom_range(0, 3) != 0) begin
            c0_en_i = 1'b0;
            c1_en_i = 1'b0;
         end
         qry_j_i = ROB_BIT'($urandom_range(0, 15));
         qry_k_i = ROB_BIT'($urandom_range(0, 15));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Commit write-port arbiter between the ROB and `register_file`. The ROB retires up to two entries per cycle, but the register file has one commit write port (`rob_en_i/rob_rd_i/rob_q_i/rob_v_i`). This block queues retired results in order and drains one per cycle into that port. It also gives the issue path a lookup over results still in flight, so a retired-but-unwritten value is never lost or stale.

## Interface
- `DEPTH`, 4: queue entries, power of two, at least 4.
- `REG_BIT`, 5: register index width.
- `ROB_BIT`, 4: ROB tag width. Tag 0 means "no dependency".
- `DAT_W`, 32: data width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: global enable. While low, all state and outputs freeze.
- `br_flag` in 1: mispredict flush from ROB.
- `c0_en_i` in 1: commit slot 0 valid. Slot 0 is older.
- `c0_rd_i` in REG_BIT: slot 0 destination register.
- `c0_q_i` in ROB_BIT: slot 0 ROB tag.
- `c0_v_i` in DAT_W: slot 0 value.
- `c1_en_i` in 1: commit slot 1 valid.
- `c1_rd_i` in REG_BIT: slot 1 destination register.
- `c1_q_i` in ROB_BIT: slot 1 ROB tag.
- `c1_v_i` in DAT_W: slot 1 value.
- `rob_stall_o` out 1: ROB must not present commits this cycle.
- `wr_en_o` out 1: to RF `rob_en_i`.
- `wr_rd_o` out REG_BIT: to RF `rob_rd_i`.
- `wr_q_o` out ROB_BIT: to RF `rob_q_i`.
- `wr_v_o` out DAT_W: to RF `rob_v_i`.
- `qry_j_i` in ROB_BIT: lookup tag, rs1.
- `qry_k_i` in ROB_BIT: lookup tag, rs2.
- `hit_j_o` out 1: pending result found for `qry_j_i`.
- `hit_k_o` out 1: pending result found for `qry_k_i`.
- `val_j_o` out DAT_W: value for the rs1 hit.
- `val_k_o` out DAT_W: value for the rs2 hit.
- `ovf_o` out 1: sticky overflow error.

## Operation
- Circular queue of `DEPTH` entries {rd, q, v}.
  - Read pointer and write pointer are `log2(DEPTH)` bits wide and wrap modulo DEPTH.
  - Count is `log2(DEPTH)+1` bits wide.
- Enqueue, per enabled cycle:
  - c0 is enqueued before c1.
  - A slot with rd == 0 is discarded: no enqueue, no count change.
  - 0, 1 or 2 entries are enqueued per cycle.
- Dequeue: when the queue is non-empty, the head entry loads into the output register with `wr_en_o`=1. Otherwise `wr_en_o`=0. At most one dequeue per cycle.
- Simultaneous enqueue and dequeue: count_next = count + enq − deq.
- Stall: `rob_stall_o` = (count ≥ DEPTH−2). It is combinational from the count register only.
- Overflow: if an enqueue would exceed DEPTH, the excess slot(s) are dropped, c1 first, and `ovf_o` sets. `ovf_o` clears only on reset.
- `br_flag`:
  - Queued entries are already-retired architectural state. They are never flushed.
  - Draining continues unchanged.
  - Commit slots presented in the same cycle as `br_flag` are still accepted.
- Lookup:
  - Combinational match of the query tag against the valid queue entries and the output register (when `wr_en_o`=1).
  - The youngest match wins; queue entries are younger than the output register.
  - A query tag of 0 never hits.
  - No match gives hit=0 and val=0.
- `en`=0: pointers, count, output register and `ovf_o` hold. Commit inputs are ignored. Lookups stay live.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - Pointers and count = 0.
  - `wr_en_o`=0, `wr_rd_o`=0, `wr_q_o`=0, `wr_v_o`=0.
  - `ovf_o`=0.
  - Queue contents are don't-care.
  - `rob_stall_o`=0 because count=0.
  - Reset mid-drain discards all entries.
- Latency: a commit sampled at edge N is enqueued at N. Without bypass it reaches the output register at N+1, so `wr_en_o` is high during cycle N+1..N+2.
- Throughput: one RF write per cycle, sustained.
- Write outputs are registered. `wr_en_o` is a one-cycle pulse per entry. Back-to-back entries give a continuous high.

## Configuration
- `RF_WBQ_BYPASS_EN` defined:
  - With the queue empty and exactly one valid, nonzero-rd slot, the slot loads directly into the output register at edge N, skipping the queue. Latency drops by one.
  - With two valid slots, the older one bypasses and the other enqueues.
- `RF_WBQ_BYPASS_EN` undefined: every entry passes through the queue.
- Ordering, stall and lookup rules are identical in both builds.

## Test plan
- Reset, then c0 = {rd=5, q=3, v=0x1234} for one cycle. Required: `wr_en_o` pulses once with rd=5, q=3, v=0x1234, one cycle after enqueue (same-edge load if bypass is on).
- c0 = {rd=1, q=1, v=0xA} and c1 = {rd=2, q=2, v=0xB} in one cycle, DEPTH=4. Required: writes occur in order q=1 then q=2 on consecutive cycles, and `rob_stall_o`=1 while count=2.
- c0.rd=0 and c1 = {rd=7, q=4, v=9}. Required: exactly one write (rd=7), and the count never exceeds 1.
- Enqueue q=6 with v=0x55 while the queue is busy, and query `qry_j_i`=6 before it drains. Required: `hit_j_o`=1, `val_j_o`=0x55. Query 0 returns hit=0.
- Pulse `br_flag` with 3 entries queued. Required: all 3 are still written in order and the count reaches 0.
- Present two commits at count=3 while ignoring the stall. Required: c0 is accepted, c1 is dropped, `ovf_o`=1 and stays set until `rst_n` is low.
